register_writeback: RTL and testbench

Write-side counterpart to the instruction decode stage. It latches the propagated 20-bit instruction and its result into a writeback pipeline register, decodes the destination field, and commits the result into a 16-entry register file. It also serves the two register-file read ports addressed by decode, with same-cycle write bypass. It sits at the end of the pipeline; its read ports feed the decode/execute boundary.

---
 rtl/register_writeback_if.sv | 29 ++
 rtl/register_writeback.sv | 73 +++++++
 tb/tb_register_writeback.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/register_writeback_if.sv
// Writeback stage bus: retiring instruction and result in, register-file read ports
// and the pending-write view out.
interface register_writeback_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid_in;
  logic                  stall;
  logic                  flush;
  logic [19:0]           instructionIn;
  logic [DATA_WIDTH-1:0] resultIn;
  logic [3:0]            ReadAddressRF1;
  logic [3:0]            ReadAddressRF2;
  logic [DATA_WIDTH-1:0] ReadDataRF1;
  logic [DATA_WIDTH-1:0] ReadDataRF2;
  logic                  WriteEnable;
  logic [3:0]            WriteAddress;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [15:0]           retireCount;

  modport master (
    output valid_in, stall, flush, instructionIn, resultIn, ReadAddressRF1, ReadAddressRF2,
    input  ReadDataRF1, ReadDataRF2, WriteEnable, WriteAddress, WriteData, retireCount
  );

  modport slave (
    input  valid_in, stall, flush, instructionIn, resultIn, ReadAddressRF1, ReadAddressRF2,
    output ReadDataRF1, ReadDataRF2, WriteEnable, WriteAddress, WriteData, retireCount
  );
endinterface

// File: rtl/register_writeback.sv
// Writeback pipeline register plus 16-entry register file with two bypassed
// combinational read ports and a committed-write counter.
module register_writeback #(
  parameter int DATA_WIDTH = 16,
  parameter bit ZERO_REG   = 1'b1
) (
  input logic            clock,
  input logic            reset,
  register_writeback_if.slave wb
);

  logic [3:0]            opcode;
  logic [3:0]            dest;
  logic                  writes;
  logic                  we_q;
  logic [3:0]            wa_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [15:0]           cnt_q;
  logic [DATA_WIDTH-1:0] regfile [16];

  assign opcode = wb.instructionIn[19:16];
  assign dest   = wb.instructionIn[15:12];

  // STORE, BRANCH and NOP retire without a register write
  always_comb begin
    writes = 1'b1;
    case (opcode)
      4'b1100, 4'b1110, 4'b1111: writes = 1'b0;
      default:                   writes = 1'b1;
    endcase
    if (ZERO_REG && dest == 4'd0) writes = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q <= 1'b0;
      wa_q <= 4'd0;
      wd_q <= '0;
    end else if (!wb.stall) begin
      if (wb.flush || !wb.valid_in) begin
        we_q <= 1'b0;
      end else begin
        we_q <= writes;
        wa_q <= dest;
        wd_q <= wb.resultIn;
      end
    end
  end

  // Commit ignores stall: a held entry rewrites the same value every edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= 16'd0;
      for (int i = 0; i < 16; i++) regfile[i] <= '0;
    end else if (we_q) begin
      regfile[wa_q] <= wd_q;
      cnt_q         <= cnt_q + 16'd1;
    end
  end

  assign wb.ReadDataRF1 = (ZERO_REG && wb.ReadAddressRF1 == 4'd0) ? '0 :
                          (we_q && wa_q == wb.ReadAddressRF1)     ? wd_q :
                          regfile[wb.ReadAddressRF1];
  assign wb.ReadDataRF2 = (ZERO_REG && wb.ReadAddressRF2 == 4'd0) ? '0 :
                          (we_q && wa_q == wb.ReadAddressRF2)     ? wd_q :
                          regfile[wb.ReadAddressRF2];

  assign wb.WriteEnable  = we_q;
  assign wb.WriteAddress = wa_q;
  assign wb.WriteData    = wd_q;
  assign wb.retireCount  = cnt_q;

endmodule

// File: tb/tb_register_writeback.sv
// Directed vector table, randomized stream against a register-file model,
// mid-stream asynchronous reset and retire counter wrap.
module tb_register_writeback;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  register_writeback_if #(.DATA_WIDTH(16)) bus ();

  register_writeback #(.DATA_WIDTH(16), .ZERO_REG(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (bus)
  );

  always #5 clock = ~clock;

  // model: architectural register file plus the one pending write
  logic [15:0] m_rf [16];
  logic        m_we;
  logic [3:0]  m_wa;
  logic [15:0] m_wd;
  logic [15:0] m_cnt;

  typedef struct {
    logic        valid, stall, flush;
    logic [19:0] instr;
    logic [15:0] res;
    logic [3:0]  ra1, ra2;
    logic        e_we;
    logic [3:0]  e_wa;
    logic [15:0] e_rd1, e_rd2, e_cnt;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
    if (m_we && m_wa == a) return m_wd;
    return m_rf[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
    m_we = 1'b0; m_wa = 4'd0; m_wd = 16'h0000; m_cnt = 16'h0000;
  endtask

  task automatic drive(input logic v, input logic s, input logic f, input logic [19:0] ins,
                       input logic [15:0] r, input logic [3:0] a1, input logic [3:0] a2);
    bus.valid_in = v; bus.stall = s; bus.flush = f;
    bus.instructionIn = ins; bus.resultIn = r;
    bus.ReadAddressRF1 = a1; bus.ReadAddressRF2 = a2;
  endtask

  // one clock edge: model commits the old pending write, then captures per the rules
  task automatic step();
    logic [3:0] op, d;
    @(posedge clock);
    if (m_we) begin
      m_rf[m_wa] = m_wd;
      m_cnt = m_cnt + 16'd1;
    end
    if (!bus.stall) begin
      if (bus.flush || !bus.valid_in) begin
        m_we = 1'b0;
      end else begin
        op = bus.instructionIn[19:16];
        d  = bus.instructionIn[15:12];
        m_we = !(op == 4'hC || op == 4'hE || op == 4'hF) && (d != 4'd0);
        m_wa = d;
        m_wd = bus.resultIn;
      end
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " we"},  {31'd0, bus.WriteEnable}, {31'd0, m_we});
    check({tag, " wa"},  {28'd0, bus.WriteAddress}, {28'd0, m_wa});
    check({tag, " wd"},  {16'd0, bus.WriteData}, {16'd0, m_wd});
    check({tag, " cnt"}, {16'd0, bus.retireCount}, {16'd0, m_cnt});
    check({tag, " rd1"}, {16'd0, bus.ReadDataRF1}, {16'd0, m_read(bus.ReadAddressRF1)});
    check({tag, " rd2"}, {16'd0, bus.ReadDataRF2}, {16'd0, m_read(bus.ReadAddressRF2)});
  endtask

  initial begin
    logic [3:0]  op, d;
    logic [19:0] ins;

    //          valid stall flush instr     res       ra1 ra2  we wa  rd1       rd2       cnt
    vecs[0]  = '{1, 0, 0, 20'h03000, 16'hBEEF, 3, 0, 1, 3, 16'hBEEF, 16'h0000, 16'd0};
    vecs[1]  = '{0, 0, 0, 20'h00000, 16'h0000, 3, 5, 0, 3, 16'hBEEF, 16'h0000, 16'd1};
    vecs[2]  = '{1, 0, 0, 20'hC5600, 16'h1234, 5, 3, 0, 5, 16'h0000, 16'hBEEF, 16'd1};
    vecs[3]  = '{1, 0, 0, 20'hF0000, 16'h1234, 5, 3, 0, 0, 16'h0000, 16'hBEEF, 16'd1};
    vecs[4]  = '{1, 0, 0, 20'h10000, 16'hFFFF, 3, 0, 0, 0, 16'hBEEF, 16'h0000, 16'd1};
    vecs[5]  = '{1, 0, 0, 20'h07000, 16'h00AA, 7, 0, 1, 7, 16'h00AA, 16'h0000, 16'd1};
    vecs[6]  = '{1, 1, 1, 20'h09000, 16'h5555, 7, 9, 1, 7, 16'h00AA, 16'h0000, 16'd2};
    vecs[7]  = '{1, 1, 1, 20'h09000, 16'h5555, 7, 9, 1, 7, 16'h00AA, 16'h0000, 16'd3};
    vecs[8]  = '{1, 1, 1, 20'h09000, 16'h5555, 7, 9, 1, 7, 16'h00AA, 16'h0000, 16'd4};
    vecs[9]  = '{1, 0, 1, 20'h09000, 16'h5555, 7, 9, 0, 7, 16'h00AA, 16'h0000, 16'd5};
    vecs[10] = '{1, 0, 0, 20'h02000, 16'h0001, 2, 2, 1, 2, 16'h0001, 16'h0001, 16'd5};
    vecs[11] = '{1, 0, 0, 20'h02000, 16'h0002, 2, 2, 1, 2, 16'h0002, 16'h0002, 16'd6};
    vecs[12] = '{0, 0, 0, 20'h00000, 16'h0000, 2, 5, 0, 2, 16'h0002, 16'h0000, 16'd7};

    drive(0, 0, 0, 20'h0, 16'h0, 4'd3, 4'd0);
    model_reset();
    #12;
    check("reset we",  {31'd0, bus.WriteEnable}, 32'd0);
    check("reset cnt", {16'd0, bus.retireCount}, 32'd0);
    check("reset rd1", {16'd0, bus.ReadDataRF1}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].valid, vecs[i].stall, vecs[i].flush, vecs[i].instr, vecs[i].res,
            vecs[i].ra1, vecs[i].ra2);
      step();
      check($sformatf("vec%0d we", i),  {31'd0, bus.WriteEnable}, {31'd0, vecs[i].e_we});
      check($sformatf("vec%0d wa", i),  {28'd0, bus.WriteAddress}, {28'd0, vecs[i].e_wa});
      check($sformatf("vec%0d rd1", i), {16'd0, bus.ReadDataRF1}, {16'd0, vecs[i].e_rd1});
      check($sformatf("vec%0d rd2", i), {16'd0, bus.ReadDataRF2}, {16'd0, vecs[i].e_rd2});
      check($sformatf("vec%0d cnt", i), {16'd0, bus.retireCount}, {16'd0, vecs[i].e_cnt});
    end

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0:       op = 4'hC;
        1:       op = 4'hE;
        2:       op = 4'hF;
        default: op = 4'($urandom_range(0, 11));
      endcase
      d   = 4'($urandom_range(0, 15));
      ins = {op, d, 12'($urandom)};
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
            ins, 16'($urandom),
            ($urandom_range(0, 2) == 0) ? m_wa : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0) ? m_wa : 4'($urandom_range(0, 15)));
      step();
      check_model($sformatf("rnd%0d", n));
    end

    // asynchronous reset between edges, held across an edge with a valid write presented
    drive(1, 0, 0, 20'h04000, 16'h7777, 4'd4, 4'd4);
    step();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async we",  {31'd0, bus.WriteEnable}, 32'd0);
    check("async wa",  {28'd0, bus.WriteAddress}, 32'd0);
    check("async wd",  {16'd0, bus.WriteData}, 32'd0);
    check("async cnt", {16'd0, bus.retireCount}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      bus.ReadAddressRF1 = 4'(a);
      bus.ReadAddressRF2 = 4'(15 - a);
      #0.1;
      check($sformatf("async rd1[%0d]", a), {16'd0, bus.ReadDataRF1}, 32'd0);
      check($sformatf("async rd2[%0d]", 15 - a), {16'd0, bus.ReadDataRF2}, 32'd0);
    end
    @(posedge clock);
    #1;
    check("reset edge we",  {31'd0, bus.WriteEnable}, 32'd0);
    check("reset edge cnt", {16'd0, bus.retireCount}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // counter wrap: a held write commits on every stalled edge
    drive(1, 0, 0, 20'h0A000, 16'h0C0C, 4'd10, 4'd0);
    step();
    check_model("wrap capture");
    bus.stall = 1'b1;
    for (int n = 0; n < 70000 && m_cnt != 16'hFFFF; n++) step();
    check_model("wrap ffff");
    step();
    check_model("wrap 0000");
    check("wrap cnt zero", {16'd0, bus.retireCount}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
